// File: rtl/ccd_pkg.sv
// Shared definitions for the toggle-encoded cross-clock trigger link.
// Both the destination-side responder and the source-side rate limiter use them.
package ccd_pkg;

  localparam int SYNC_STG_MIN = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_SAT   = 2'd2
  } ccd_state_e;

  // Largest trigger count a w-bit pending counter can hold.
  function automatic int pend_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// Multi-flop level synchroniser for a single foreign-domain bit.
// Asynchronous active-low reset to 0.
module cdc_sync_chain #(
  parameter int STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STG-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STG; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STG-1];

endmodule

// File: rtl/ccd_trigger_responder.sv
// Destination side of the toggle trigger link: decodes toggle edges into events,
// queues them in a saturating counter and hands them out on a valid/ready port.
module ccd_trigger_responder
  import ccd_pkg::*;
#(
  parameter int SYNC_STG = 2,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tog_i,
  output logic             trig_valid,
  input  logic             trig_ready,
  output logic             ack_o,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_max(CNT_W));

  if (SYNC_STG < SYNC_STG_MIN) begin : g_stg_chk
    $error("ccd_trigger_responder: SYNC_STG must be at least SYNC_STG_MIN");
  end

  // Saturating step of the pending count; the MSB of the result flags a dropped event.
  function automatic logic [CNT_W:0] sat_step(input logic [CNT_W-1:0] cur,
                                              input logic             ev,
                                              input logic             cons);
    logic [CNT_W-1:0] nxt;
    logic             drop;
    nxt  = cur;
    drop = 1'b0;
    if (ev && !cons) begin
      if (cur == PEND_MAX) drop = 1'b1;
      else                 nxt  = cur + 1'b1;
    end else if (!ev && cons) begin
      nxt = cur - 1'b1;
    end
    return {drop, nxt};
  endfunction

  logic             tog_sync_p0;
  logic             tog_ref_p1;
  logic             ev_p1;
  logic             consume;
  logic             drop;
  logic [CNT_W-1:0] pend_nxt;
  ccd_state_e       state, state_nxt;

  cdc_sync_chain #(.STG(SYNC_STG)) u_tog_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tog_i),
    .q     (tog_sync_p0)
  );

  // Stage p1: edge decode, registered so the counter sees a flip SYNC_STG+1 edges after sampling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_ref_p1 <= 1'b0;
      ev_p1      <= 1'b0;
    end else begin
      tog_ref_p1 <= tog_sync_p0;
      ev_p1      <= tog_sync_p0 ^ tog_ref_p1;
    end
  end

  assign consume = trig_valid & trig_ready;

  always_comb begin
    {drop, pend_nxt} = sat_step(pending, ev_p1, consume);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (pend_nxt != '0) state_nxt = (pend_nxt == PEND_MAX) ? ST_SAT : ST_PEND;
      ST_PEND: begin
        if (pend_nxt == '0)            state_nxt = ST_EMPTY;
        else if (pend_nxt == PEND_MAX) state_nxt = ST_SAT;
      end
      ST_SAT:   if (pend_nxt != PEND_MAX) state_nxt = (pend_nxt == '0) ? ST_EMPTY : ST_PEND;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Stage p2: counter, FSM and all outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      pending    <= '0;
      trig_valid <= 1'b0;
      ack_o      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pend_nxt;
      trig_valid <= (state_nxt != ST_EMPTY);
      if (consume) ack_o <= ~ack_o;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ccd_trigger_responder.sv
// Directed and randomized checks of the trigger responder against a cycle-level reference model.
module tb_ccd_trigger_responder;

  localparam int SYNC_STG = 2;
  localparam int LAT      = SYNC_STG + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       tog   = 1'b0;
  logic       ready = 1'b0;
  logic       clr   = 1'b0;
  logic       va, acka, ova;
  logic [3:0] pa;
  logic       vb, ackb, ovb;
  logic [1:0] pb;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: index 0 is the CNT_W=4 instance, index 1 the CNT_W=2 instance
  int mp[2];
  int mack[2];
  int movf[2];
  int maxv[2] = '{15, 3};
  bit hist[LAT+2];

  always #5 clk = ~clk;

  ccd_trigger_responder #(.SYNC_STG(SYNC_STG), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tog_i(tog), .trig_valid(va), .trig_ready(ready),
    .ack_o(acka), .pending(pa), .overflow(ova), .ovf_clr(clr)
  );

  ccd_trigger_responder #(.SYNC_STG(SYNC_STG), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tog_i(tog), .trig_valid(vb), .trig_ready(ready),
    .ack_o(ackb), .pending(pb), .overflow(ovb), .ovf_clr(clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A level change sampled at edge k becomes an event at edge k+LAT.
  task automatic model_edge();
    bit ev, cons, set;
    ev = hist[LAT] ^ hist[LAT+1];
    for (int i = LAT + 1; i > 1; i--) hist[i] = hist[i-1];
    hist[1] = tog;
    for (int i = 0; i < 2; i++) begin
      cons = (mp[i] != 0) && ready;
      set  = 1'b0;
      if (ev && !cons) begin
        if (mp[i] == maxv[i]) set = 1'b1;
        else                  mp[i]++;
      end else if (!ev && cons) begin
        mp[i]--;
      end
      if (cons) mack[i] = mack[i] ^ 1;
      if (set)      movf[i] = 1;
      else if (clr) movf[i] = 0;
    end
  endtask

  task automatic cmp_all();
    chk("a_pending", 32'(pa),   32'(mp[0]));
    chk("a_valid",   32'(va),   32'(mp[0] != 0));
    chk("a_ack",     32'(acka), 32'(mack[0]));
    chk("a_ovf",     32'(ova),  32'(movf[0]));
    chk("b_pending", 32'(pb),   32'(mp[1]));
    chk("b_valid",   32'(vb),   32'(mp[1] != 0));
    chk("b_ack",     32'(ackb), 32'(mack[1]));
    chk("b_ovf",     32'(ovb),  32'(movf[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  // Asserts reset between edges, checks the immediate effect, releases with tog low.
  task automatic do_reset();
    #2;
    tog   = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mp[i] = 0; mack[i] = 0; movf[i] = 0;
    end
    for (int i = 0; i < LAT + 2; i++) hist[i] = 1'b0;
    #1;
    cmp_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic flips(input int n);
    for (int k = 0; k < n; k++) begin
      tog = ~tog;
      repeat (4) tick();
    end
  endtask

  initial begin
    int gap;
    #1;
    do_reset();

    // Single trigger: sampled at edge 0, pending at edge 3, consumed at edge 4
    ready = 1'b1;
    tog   = 1'b1;
    repeat (4) tick();
    chk("t1_pending_e3", 32'(pa), 32'd1);
    chk("t1_valid_e3",   32'(va), 32'd1);
    tick();
    chk("t1_pending_e4", 32'(pa),   32'd0);
    chk("t1_ack_e4",     32'(acka), 32'd1);

    // Backpressure then drain
    do_reset();
    ready = 1'b0;
    flips(5);
    chk("t2_pending", 32'(pa), 32'd5);
    chk("t2_valid",   32'(va), 32'd1);
    ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t2_ack_flip", 32'(acka), 32'(k & 1));
    end
    chk("t2_drained", 32'(pa), 32'd0);
    chk("t2_ack_end", 32'(acka), 32'd1);
    ready = 1'b0;

    // Saturation on the 2-bit instance, then clear
    do_reset();
    flips(4);
    chk("t3_pending_sat", 32'(pb),  32'd3);
    chk("t3_ovf_set",     32'(ovb), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_ovf_clr",     32'(ovb), 32'd0);
    chk("t3_pending_hold", 32'(pb), 32'd3);

    // Event and consume on the same edge at PEND_MAX
    tog = ~tog;
    repeat (3) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t4_pending_max", 32'(pb),  32'd3);
    chk("t4_no_ovf",      32'(ovb), 32'd0);

    // Clear collides with a saturating drop: set wins
    tog = ~tog;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_set_wins", 32'(ovb), 32'd1);
    tick();
    chk("t5_ovf_sticky", 32'(ovb), 32'd1);

    // Reset mid-operation
    do_reset();
    flips(2);
    chk("t6_pending_pre", 32'(pa), 32'd2);
    do_reset();
    chk("t6_pending_rst", 32'(pa), 32'd0);
    chk("t6_valid_rst",   32'(va), 32'd0);
    repeat (6) begin
      tick();
      chk("t6_no_spurious", 32'(va), 32'd0);
    end

    // Randomized traffic respecting the sender's spacing contract
    gap = LAT;
    repeat (600) begin
      gap++;
      if (gap >= LAT && $urandom_range(0, 2) == 0) begin
        tog = ~tog;
        gap = 0;
      end
      ready = ($urandom_range(0, 9) < 4);
      clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        gap = LAT;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
